// File: rtl/lvt_pkg.sv
// Shared defaults for the LVT write scheduler and its pick logic.
// Latency: none. This file holds only constants and a helper function.
// Backpressure: not applicable.
package lvt_pkg;

    localparam int LVT_WIDTH = 32;   // data word width
    localparam int LVT_DEPTH = 512;  // memory words
    localparam int LVT_PORTS = 4;    // LVT write ports
    localparam int LVT_REQS  = 8;    // requesters arbitrated
    localparam int LVT_CNT_W = 16;   // conflict counter width

    // Increment that sticks at all-ones rather than wrapping.
    function automatic logic [LVT_CNT_W-1:0] cnt_sat_inc(input logic [LVT_CNT_W-1:0] c);
        return (c == '1) ? c : c + LVT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/lvt_sched_pick.sv
// Combinational round-robin scan: grants up to PORTS address-unique requests per cycle.
// Latency: zero (pure combinational); the caller registers the port outputs.
// Backpressure: a request is not readied when the ports are exhausted or its address is already granted.
//
// Ports: rr (scan start), req_valid/req_addr/req_data (requests), req_ready (grants),
//        pick_en/pick_addr/pick_data (k-th grant on port k), next_rr, conflict (address-only deferral).
module lvt_sched_pick
    import lvt_pkg::*;
#(
    parameter  int WIDTH = LVT_WIDTH,
    parameter  int DEPTH = LVT_DEPTH,
    parameter  int PORTS = LVT_PORTS,
    parameter  int REQS  = LVT_REQS,
    localparam int AW    = $clog2(DEPTH),
    localparam int RW    = (REQS > 1) ? $clog2(REQS) : 1,
    localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [RW-1:0]                 rr,
    input  logic [REQS-1:0]               req_valid,
    input  logic [REQS-1:0][AW-1:0]       req_addr,
    input  logic [REQS-1:0][WIDTH-1:0]    req_data,
    output logic [REQS-1:0]               req_ready,
    output logic [PORTS-1:0]              pick_en,
    output logic [PORTS-1:0][AW-1:0]      pick_addr,
    output logic [PORTS-1:0][WIDTH-1:0]   pick_data,
    output logic [RW-1:0]                 next_rr,
    output logic                          conflict
);

    logic [PW:0]   gcnt;      // grants so far this cycle, 0..PORTS
    logic [RW-1:0] idx;       // requester being scanned
    logic [RW-1:0] last_idx;  // last requester granted
    logic          grant_any;
    logic          hit;       // address already owned by an earlier grant

    always_comb begin
        req_ready = '0;
        pick_en   = '0;
        pick_addr = '0;
        pick_data = '0;
        gcnt      = '0;
        idx       = '0;
        last_idx  = '0;
        grant_any = 1'b0;
        hit       = 1'b0;
        conflict  = 1'b0;

        for (int s = 0; s < REQS; s++) begin
            idx = RW'((int'(rr) + s) % REQS);
            hit = 1'b0;
            // Only ports already filled this cycle have pick_en set, so this
            // compares against exactly the addresses granted so far.
            for (int k = 0; k < PORTS; k++) begin
                if (pick_en[k] && (pick_addr[k] == req_addr[idx])) begin
                    hit = 1'b1;
                end
            end
            // Once all ports are taken, remaining requesters are deferred by
            // exhaustion and are deliberately not counted as conflicts.
            if (req_valid[idx] && (gcnt < (PW+1)'(PORTS))) begin
                if (hit) begin
                    conflict = 1'b1;
                end else begin
                    req_ready[idx]             = 1'b1;
                    pick_en[gcnt[PW-1:0]]      = 1'b1;
                    pick_addr[gcnt[PW-1:0]]    = req_addr[idx];
                    pick_data[gcnt[PW-1:0]]    = req_data[idx];
                    last_idx                   = idx;
                    grant_any                  = 1'b1;
                    gcnt                       = gcnt + (PW+1)'(1);
                end
            end
        end

        if (!grant_any) begin
            next_rr = rr;
        end else if (last_idx == RW'(REQS - 1)) begin
            next_rr = '0;
        end else begin
            next_rr = last_idx + RW'(1);
        end
    end

endmodule

// File: rtl/lvt_write_scheduler.sv
// Schedules up to PORTS address-unique write requests per cycle onto LVT memory write ports.
// Latency: 1 cycle from handshake to port_en/port_addr/port_d.
// Backpressure: req_ready is combinational; deferred requesters must hold valid until readied.
//
// Ports: clk, rst_n (async active-low); req_valid/req_addr/req_data/req_ready per requester;
//        port_en/port_addr/port_d per LVT write port (registered); conflict_cnt (saturating).
module lvt_write_scheduler
    import lvt_pkg::*;
#(
    parameter  int WIDTH = LVT_WIDTH,
    parameter  int DEPTH = LVT_DEPTH,
    parameter  int PORTS = LVT_PORTS,
    parameter  int REQS  = LVT_REQS,
    localparam int AW    = $clog2(DEPTH),
    localparam int RW    = (REQS > 1) ? $clog2(REQS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [REQS-1:0]               req_valid,
    input  logic [REQS-1:0][AW-1:0]       req_addr,
    input  logic [REQS-1:0][WIDTH-1:0]    req_data,
    output logic [REQS-1:0]               req_ready,
    output logic [PORTS-1:0]              port_en,
    output logic [PORTS-1:0][AW-1:0]      port_addr,
    output logic [PORTS-1:0][WIDTH-1:0]   port_d,
    output logic [LVT_CNT_W-1:0]          conflict_cnt
);

    logic [RW-1:0]                rr_q, rr_d;
    logic [PORTS-1:0]             port_en_q, port_en_d;
    logic [PORTS-1:0][AW-1:0]     port_addr_q, port_addr_d;
    logic [PORTS-1:0][WIDTH-1:0]  port_d_q, port_d_d;
    logic [LVT_CNT_W-1:0]         conflict_cnt_q, conflict_cnt_d;

    logic [REQS-1:0]              valid_g;
    logic [PORTS-1:0]             pick_en;
    logic [PORTS-1:0][AW-1:0]     pick_addr;
    logic [PORTS-1:0][WIDTH-1:0]  pick_data;
    logic [RW-1:0]                next_rr;
    logic                         conflict;

    // Masking valid with reset keeps req_ready low while in reset, so no
    // requester believes it handed off a write that will be discarded.
    assign valid_g = req_valid & {REQS{rst_n}};

    lvt_sched_pick #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PORTS (PORTS),
        .REQS  (REQS)
    ) u_pick (
        .rr        (rr_q),
        .req_valid (valid_g),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .pick_en   (pick_en),
        .pick_addr (pick_addr),
        .pick_data (pick_data),
        .next_rr   (next_rr),
        .conflict  (conflict)
    );

    always_comb begin
        rr_d           = next_rr;
        port_en_d      = pick_en;
        port_addr_d    = port_addr_q;
        port_d_d       = port_d_q;
        conflict_cnt_d = conflict ? cnt_sat_inc(conflict_cnt_q) : conflict_cnt_q;
        // Unused ports keep their last address/data; only the enable drops.
        for (int k = 0; k < PORTS; k++) begin
            if (pick_en[k]) begin
                port_addr_d[k] = pick_addr[k];
                port_d_d[k]    = pick_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q           <= '0;
            port_en_q      <= '0;
            port_addr_q    <= '0;
            port_d_q       <= '0;
            conflict_cnt_q <= '0;
        end else begin
            rr_q           <= rr_d;
            port_en_q      <= port_en_d;
            port_addr_q    <= port_addr_d;
            port_d_q       <= port_d_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign port_en      = port_en_q;
    assign port_addr    = port_addr_q;
    assign port_d       = port_d_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_lvt_write_scheduler.sv
// Scoreboard bench for lvt_write_scheduler at PORTS=4, REQS=8.
// Latency: expectations are queued at drive time and compared one cycle later.
// Backpressure: request patterns deliberately overload ports and collide addresses.
module tb_lvt_write_scheduler;

    localparam int W  = 32;
    localparam int AW = 9;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [7:0]            req_valid;
    logic [7:0][AW-1:0]    req_addr;
    logic [7:0][W-1:0]     req_data;
    logic [7:0]            req_ready;
    logic [3:0]            port_en;
    logic [3:0][AW-1:0]    port_addr;
    logic [3:0][W-1:0]     port_d;
    logic [15:0]           conflict_cnt;

    lvt_write_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .port_en      (port_en),
        .port_addr    (port_addr),
        .port_d       (port_d),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]         en;
        logic [3:0][AW-1:0] addr;
        logic [3:0][W-1:0]  d;
        logic [15:0]        cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [7:0]          m_rdy;
    logic [3:0]          m_en;
    logic [3:0][AW-1:0]  m_paddr;
    logic [3:0][W-1:0]   m_pd;
    int                  m_rr;
    int                  m_cnt;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rr    = 0;
        m_cnt   = 0;
        m_paddr = '0;
        m_pd    = '0;
        m_en    = '0;
    endtask

    // Walk requesters from the pointer, keeping a list of addresses taken.
    task automatic predict(input logic [7:0] v);
        logic [AW-1:0] taken[$];
        int  g;
        int  last;
        bit  clash;
        bit  conf;
        g = 0; last = -1; conf = 0;
        m_rdy = '0;
        m_en  = '0;
        for (int s = 0; s < 8; s++) begin
            int i;
            i = (m_rr + s) % 8;
            if (v[i] && g < 4) begin
                clash = 0;
                foreach (taken[j]) if (taken[j] == req_addr[i]) clash = 1;
                if (clash) begin
                    conf = 1;
                end else begin
                    m_rdy[i]   = 1'b1;
                    m_en[g]    = 1'b1;
                    m_paddr[g] = req_addr[i];
                    m_pd[g]    = req_data[i];
                    taken.push_back(req_addr[i]);
                    last = i;
                    g++;
                end
            end
        end
        if (last >= 0) m_rr = (last + 1) % 8;
        if (conf && m_cnt < 65535) m_cnt++;
    endtask

    // Called at posedge+1: drive, check ready mid-cycle, check ports after the edge.
    task automatic step(input logic [7:0] v, input string tag,
                        input logic [7:0] exp_rdy, input bit use_const);
        exp_t e;
        for (int i = 0; i < 8; i++) req_data[i] = $urandom;
        req_valid = v;
        predict(v);
        e.en = m_en; e.addr = m_paddr; e.d = m_pd; e.cnt = 16'(m_cnt);
        exp_q.push_back(e);
        #3;
        chk({tag, "_rdy"}, 128'(req_ready), 128'(m_rdy));
        if (use_const) chk({tag, "_rdyc"}, 128'(req_ready), 128'(exp_rdy));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_en"},   128'(port_en),      128'(e.en));
        chk({tag, "_addr"}, 128'(port_addr),    128'(e.addr));
        chk({tag, "_d"},    128'(port_d),       128'(e.d));
        chk({tag, "_cnt"},  128'(conflict_cnt), 128'(e.cnt));
    endtask

    task automatic set_addrs(input int base);
        for (int i = 0; i < 8; i++) req_addr[i] = AW'(base + i);
    endtask

    logic [3:0][AW-1:0] pa;

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        set_addrs(100);
        for (int i = 0; i < 8; i++) req_data[i] = $urandom;
        model_reset();

        // Reset with every requester asking
        #12;
        chk("rst_rdy",   128'(req_ready),    128'(0));
        chk("rst_en",    128'(port_en),      128'(0));
        chk("rst_cnt",   128'(conflict_cnt), 128'(0));
        chk("rst_addr",  128'(port_addr),    128'(0));
        chk("rst_d",     128'(port_d),       128'(0));
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Four requesters, four ports
        set_addrs(100);
        for (int i = 0; i < 4; i++) req_addr[i] = AW'(10 + i);
        step(8'h0F, "r032", 8'h0F, 1);
        pa = {9'd13, 9'd12, 9'd11, 9'd10};
        chk("r032_en4", 128'(port_en),   128'(4'hF));
        chk("r032_pa",  128'(port_addr), 128'(pa));

        // Pointer now at 4: all valid -> 4..7 win, exhaustion is not a conflict
        set_addrs(20);
        step(8'hFF, "rr4", 8'hF0, 1);
        chk("rr4_nocnt", 128'(conflict_cnt), 128'(0));

        // Move pointer to 6, then wrap-around grant order
        step(8'h20, "rr6", 8'h20, 1);
        chk("rr6_hold", 128'(port_addr[3]), 128'(27));
        step(8'hFF, "r033", 8'hC3, 1);
        pa = {9'd21, 9'd20, 9'd27, 9'd26};
        chk("r033_pa", 128'(port_addr), 128'(pa));
        step(8'hFF, "r033rr", 8'h3C, 1);

        // Pointer to 0, then an address collision between 2 and 5
        step(8'h80, "rr0", 8'h80, 1);
        req_addr[2] = 9'd7;
        req_addr[5] = 9'd7;
        step(8'h24, "r034a", 8'h04, 1);
        chk("r034a_cnt1", 128'(conflict_cnt), 128'(1));
        step(8'h24, "r034b", 8'h20, 1);
        chk("r034b_cnt2", 128'(conflict_cnt), 128'(2));
        step(8'h24, "wrap", 8'h04, 1);

        // Paired addresses: collisions and exhaustion in one cycle
        for (int i = 0; i < 8; i++) req_addr[i] = AW'(30 + i / 2);
        step(8'hFF, "dup", 8'h59, 1);
        chk("dup_cnt4", 128'(conflict_cnt), 128'(4));

        // Random traffic on a narrow address range
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) req_addr[i] = AW'($urandom_range(0, 5));
            step(8'($urandom), "rnd", 8'h00, 0);
        end

        // Sustained conflict: counter must stick at all-ones
        req_addr[2] = 9'd7;
        req_addr[5] = 9'd7;
        req_valid   = 8'h24;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat", 128'(conflict_cnt), 128'(16'hFFFF));
        @(posedge clk); #1;
        chk("sat_hold", 128'(conflict_cnt), 128'(16'hFFFF));

        // Grant registered, then reset: no stale port_en after release
        req_valid = 8'h01;
        @(posedge clk); #1;
        chk("r036_pre", 128'(port_en), 128'(4'h1));
        req_valid = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("r036_en_rst",  128'(port_en),      128'(0));
        chk("r036_cnt_rst", 128'(conflict_cnt), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("r036_post", 128'(port_en), 128'(0));
        end
        model_reset();
        set_addrs(40);
        step(8'hFF, "post_rst", 8'h0F, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lvt_write_scheduler.md
LVT_WRITE_SCHEDULER -- requirements
Module: lvt_write_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 512, memory words; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter PORTS, default 4, LVT memory write ports driven.
REQ-004 SHALL have parameter REQS, default 8, requesters arbitrated; REQS >= 1.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, [REQS], per-requester write request.
REQ-008 SHALL have port req_addr, input, [REQS][AW], per-requester write address.
REQ-009 SHALL have port req_data, input, [REQS][WIDTH], per-requester write data.
REQ-010 SHALL have port req_ready, output, [REQS], per-requester grant; combinational.
REQ-011 SHALL have port port_en, output, [PORTS], LVT write enable per port; registered.
REQ-012 SHALL have port port_addr, output, [PORTS][AW], LVT address per port; registered.
REQ-013 SHALL have port port_d, output, [PORTS][WIDTH], LVT write data per port; registered.
REQ-014 SHALL have port conflict_cnt, output, 16, saturating count of conflict cycles.

Function
REQ-015 Each cycle SHALL scan requesters in order rr, rr+1, ... mod REQS; rr is the 0..REQS-1 round-robin pointer.
REQ-016 A scanned requester with req_valid=1 SHALL be granted only if fewer than PORTS grants exist so far this cycle and its req_addr differs from every address already granted this cycle.
REQ-017 Transfer SHALL occur only when req_valid[i]=1 and req_ready[i]=1 in the same cycle; req_ready[i] SHALL be 0 when req_valid[i]=0.
REQ-018 The k-th grant in scan order SHALL drive port k; ports k >= grant count SHALL have port_en=0 the next cycle.
REQ-019 Latency SHALL be 1 cycle: port_en/port_addr/port_d reflect the grants of the previous cycle; port_addr/port_d of unused ports hold their previous values.
REQ-020 rr SHALL update to (index of last granted requester + 1) mod REQS; with no grant, rr SHALL be unchanged.
REQ-021 A valid request deferred only by address match SHALL mark the cycle as a conflict cycle; conflict_cnt SHALL increment by 1 per conflict cycle and saturate at 16'hFFFF.
REQ-022 A valid request deferred by port exhaustion SHALL NOT count as a conflict.
REQ-023 When REQS <= PORTS, every valid request with a unique address SHALL be granted the same cycle.
REQ-024 Two ports SHALL never carry the same address with port_en=1 in the same cycle.
REQ-025 No two requesters SHALL be granted in the same cycle with the same address, including across rr wrap-around.

Reset
REQ-026 While rst_n=0: port_en, port_addr, port_d, rr and conflict_cnt SHALL be 0.
REQ-027 While rst_n=0, req_ready SHALL be 0 for all requesters.
REQ-028 A grant registered before a reset asserted mid-operation SHALL be discarded; no port_en pulse SHALL follow reset release without a new handshake.

Structure
REQ-029 Shared package lvt_pkg SHALL hold default WIDTH/DEPTH/PORTS/REQS constants and the conflict counter width.
REQ-030 The combinational scan/grant/port-assignment logic SHALL be one sub-module, lvt_sched_pick; pointer, output and counter registers SHALL stay in lvt_write_scheduler.

Verification (PORTS=4, REQS=8)
REQ-031 Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, port_en=0, conflict_cnt=0.
REQ-032 Requesters 0..3 valid, addresses 10,11,12,13, rr=0 -> ready=0x0F; next cycle port_en=4'hF, port_addr={13,12,11,10}, rr=4.
REQ-033 All 8 valid, distinct addresses, rr=6 -> grants 6,7,0,1 on ports 0..3; next rr=2.
REQ-034 Requesters 2 and 5 valid, both address 7, rr=0 -> only req 2 granted; conflict_cnt 0->1; next cycle rr=3, req 5 granted.
REQ-035 Conflict held for 70000 cycles -> conflict_cnt stops at 16'hFFFF.
REQ-036 Grant in cycle N, rst_n low in cycle N+1 -> port_en stays 0 after release until a new handshake.
